// File: rtl/packet_buffer_reader_if.sv
// Interface for packet_buffer_reader: buffer read port (rd_*) and descriptor injection port (out_*).
// The master modport is the reader engine; the slave modport is the buffer/consumer side.
interface packet_buffer_reader_if #(
    parameter int N     = 4,
    parameter int WIDTH = 32,
    parameter int LOGN  = 2
);
    logic [N-1:0]     rd_ready;
    logic [N-1:0]     rd_select;
    logic [WIDTH-1:0] rd_packet;
    logic             out_valid;
    logic [WIDTH-1:0] out_packet;
    logic [LOGN-1:0]  out_pp;
    logic             out_ack;
    logic [15:0]      sent_count;

    modport master (
        input  rd_ready, rd_packet, out_ack,
        output rd_select, out_valid, out_packet, out_pp, sent_count
    );

    modport slave (
        output rd_ready, rd_packet, out_ack,
        input  rd_select, out_valid, out_packet, out_pp, sent_count
    );
endinterface

// File: rtl/packet_buffer_reader.sv
// Round-robin read engine: pops one descriptor per grant from a per-PP buffer and holds it on a valid/ack port.
// Optional feature macro TIMESTAMP_GATE_EN: delays out_valid until the descriptor timestamp is due.
module packet_buffer_reader #(
    parameter int N        = 4,
    parameter int WIDTH    = 32,
    parameter int TS_LSB   = 0,
    parameter int TS_WIDTH = 8,
    localparam int LOGN    = (N > 1) ? $clog2(N) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic [TS_WIDTH-1:0] sim_time,
    packet_buffer_reader_if.master bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [LOGN-1:0]   out_pp_q, out_pp_d;
    logic [LOGN-1:0]   rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0]  out_packet_q, out_packet_d;
    logic [15:0]       sent_count_q, sent_count_d;

    logic [LOGN-1:0]   grant_s;
    logic [LOGN-1:0]   cand_s;
    logic              found_s;
    logic [LOGN-1:0]   rr_next_s;
    logic [N-1:0]      rd_select_s;
    logic              gate_open_s;
    logic              out_valid_s;
    logic [TS_WIDTH-1:0] ts_s;

    assign ts_s = out_packet_q[TS_LSB +: TS_WIDTH];

`ifdef TIMESTAMP_GATE_EN
    // Wrap-aware "due" test: due once sim_time is at or past ts within half the timestamp range.
    function automatic logic ts_due(input logic [TS_WIDTH-1:0] now, input logic [TS_WIDTH-1:0] ts);
        logic [TS_WIDTH-1:0] diff;
        diff = now - ts;
        return ~diff[TS_WIDTH-1];
    endfunction

    assign gate_open_s = ts_due(sim_time, ts_s);
`else
    logic unused_s;
    assign unused_s    = ^{sim_time, ts_s};
    assign gate_open_s = 1'b1;
`endif

    // Handshake is frozen along with the FSM while enable is low, so valid is masked too.
    assign out_valid_s = (state_q == HOLD) && gate_open_s && enable;

    // Round-robin search: first requesting PP at or after rr_ptr, wrapping modulo N.
    always_comb begin
        grant_s = '0;
        cand_s  = '0;
        found_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            cand_s = LOGN'((int'(rr_ptr_q) + i) % N);
            if (!found_s && bus.rd_ready[cand_s]) begin
                found_s = 1'b1;
                grant_s = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign rr_next_s = LOGN'((int'(out_pp_q) + 1) % N);

    // One-hot pop strobe, only in READ and only while enabled.
    always_comb begin
        rd_select_s = '0;
        for (int i = 0; i < N; i++) begin
            rd_select_s[i] = (state_q == READ) && enable && (out_pp_q == LOGN'(i));
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d      = state_q;
        out_pp_d     = out_pp_q;
        rr_ptr_d     = rr_ptr_q;
        out_packet_d = out_packet_q;
        sent_count_d = sent_count_q;
        case (state_q)
            IDLE: begin
                if (enable && found_s) begin
                    out_pp_d = grant_s;
                    state_d  = READ;
                end else begin
                    state_d  = IDLE;
                end
            end
            READ: begin
                if (enable) begin
                    rr_ptr_d = rr_next_s;
                    state_d  = CAPTURE;
                end else begin
                    state_d  = READ;
                end
            end
            // The pop already happened, so the returned data is captured even if enable just dropped.
            CAPTURE: begin
                out_packet_d = bus.rd_packet;
                state_d      = HOLD;
            end
            HOLD: begin
                if (out_valid_s && bus.out_ack) begin
                    state_d = IDLE;
                    if (sent_count_q != 16'hFFFF) begin
                        sent_count_d = sent_count_q + 16'd1;
                    end else begin
                        sent_count_d = sent_count_q;
                    end
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            out_pp_q     <= '0;
            rr_ptr_q     <= '0;
            out_packet_q <= '0;
            sent_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            out_pp_q     <= out_pp_d;
            rr_ptr_q     <= rr_ptr_d;
            out_packet_q <= out_packet_d;
            sent_count_q <= sent_count_d;
        end
    end

    assign bus.rd_select  = rd_select_s;
    assign bus.out_valid  = out_valid_s;
    assign bus.out_packet = out_packet_q;
    assign bus.out_pp     = out_pp_q;
    assign bus.sent_count = sent_count_q;

endmodule

// File: tb/tb_packet_buffer_reader.sv
// Directed bench for packet_buffer_reader; timestamp-gate steps run only when TIMESTAMP_GATE_EN is defined.
module tb_packet_buffer_reader;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] sim_time;
    int         tests_run = 0;
    int         tests_failed = 0;
    logic [3:0] exp_sel;

    packet_buffer_reader_if #(.N(4), .WIDTH(32), .LOGN(2)) bus ();

    packet_buffer_reader #(.N(4), .WIDTH(32), .TS_LSB(0), .TS_WIDTH(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .sim_time (sim_time),
        .bus      (bus.master)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset        = 1'b0;
        enable       = 1'b1;
        sim_time     = 8'h7F;
        bus.rd_ready  = 4'b0000;
        bus.rd_packet = 32'hDEAD_0000;
        bus.out_ack   = 1'b0;

        // 1: held in reset
        for (int c = 0; c < 20; c++) begin
            step();
            chk("rst_rd_select", {28'd0, bus.rd_select}, 32'd0);
            chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
            chk("rst_sent_count", {16'd0, bus.sent_count}, 32'd0);
        end
        chk("rst_out_packet", bus.out_packet, 32'd0);
        chk("rst_out_pp", {30'd0, bus.out_pp}, 32'd0);
        reset = 1'b1;
        step();
        chk("idle_out_valid", {31'd0, bus.out_valid}, 32'd0);

        // 2: single pop from PP2
        bus.rd_ready = 4'b0100;
        step();
        chk("t2_rd_select", {28'd0, bus.rd_select}, 32'h4);
        chk("t2_out_valid_read", {31'd0, bus.out_valid}, 32'd0);
        bus.rd_ready = 4'b0000;
        step();
        chk("t2_rd_select_capture", {28'd0, bus.rd_select}, 32'd0);
        chk("t2_out_valid_capture", {31'd0, bus.out_valid}, 32'd0);
        bus.rd_packet = 32'hCAFE_0010;
        step();
        chk("t2_out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("t2_out_packet", bus.out_packet, 32'hCAFE_0010);
        chk("t2_out_pp", {30'd0, bus.out_pp}, 32'd2);
        bus.rd_packet = 32'hDEAD_0000;
        bus.out_ack   = 1'b1;
        step();
        chk("t2_out_valid_after_ack", {31'd0, bus.out_valid}, 32'd0);
        chk("t2_sent_count", {16'd0, bus.sent_count}, 32'd1);
        bus.out_ack = 1'b0;

        // 3: round robin with all PPs requesting and ack always high (fresh reset so rr_ptr=0)
        reset = 1'b0;
        step();
        chk("t3_sent_after_reset", {16'd0, bus.sent_count}, 32'd0);
        reset        = 1'b1;
        bus.rd_ready = 4'b1111;
        bus.out_ack  = 1'b1;
        for (int g = 0; g < 5; g++) begin
            exp_sel = 4'b0001 << (g % 4);
            step();
            chk("t3_rd_select", {28'd0, bus.rd_select}, {28'd0, exp_sel});
            step();
            chk("t3_rd_select_capture", {28'd0, bus.rd_select}, 32'd0);
            bus.rd_packet = 32'h1000_0000 + g;
            step();
            chk("t3_out_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("t3_out_packet", bus.out_packet, 32'h1000_0000 + g);
            chk("t3_out_pp", {30'd0, bus.out_pp}, g % 4);
            bus.rd_packet = 32'hDEAD_0000;
            step();
            chk("t3_out_valid_idle", {31'd0, bus.out_valid}, 32'd0);
            chk("t3_sent_count", {16'd0, bus.sent_count}, g + 1);
        end

        // 4: long HOLD without ack; rd_ready changes are ignored
        bus.rd_ready = 4'b0010;
        bus.out_ack  = 1'b0;
        step();
        chk("t4_rd_select", {28'd0, bus.rd_select}, 32'h2);
        bus.rd_ready = 4'b0000;
        step();
        bus.rd_packet = 32'hA5A5_0042;
        step();
        bus.rd_packet = 32'hDEAD_0000;
        bus.rd_ready  = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            chk("t4_out_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("t4_out_packet", bus.out_packet, 32'hA5A5_0042);
            chk("t4_out_pp", {30'd0, bus.out_pp}, 32'd1);
            chk("t4_rd_select", {28'd0, bus.rd_select}, 32'd0);
            step();
        end
        bus.out_ack = 1'b1;
        step();
        chk("t4_out_valid_after_ack", {31'd0, bus.out_valid}, 32'd0);
        chk("t4_sent_count", {16'd0, bus.sent_count}, 32'd6);
        bus.rd_ready = 4'b0000;
        bus.out_ack  = 1'b0;

        // enable dropped in CAPTURE: data still captured, FSM frozen in HOLD
        bus.rd_ready = 4'b0001;
        step();
        chk("en_rd_select", {28'd0, bus.rd_select}, 32'h1);
        bus.rd_ready = 4'b0000;
        step();
        enable        = 1'b0;
        bus.rd_packet = 32'h0BAD_F00D;
        #1;
        chk("en_rd_select_capture", {28'd0, bus.rd_select}, 32'd0);
        step();
        bus.rd_packet = 32'hDEAD_0000;
        chk("en_out_packet", bus.out_packet, 32'h0BAD_F00D);
        bus.out_ack = 1'b1;
        step();
        step();
        chk("en_sent_frozen", {16'd0, bus.sent_count}, 32'd6);
        chk("en_out_packet_frozen", bus.out_packet, 32'h0BAD_F00D);
        bus.out_ack = 1'b0;
        enable      = 1'b1;
        #1;
        chk("en_out_valid_resume", {31'd0, bus.out_valid}, 32'd1);
        bus.out_ack = 1'b1;
        step();
        chk("en_out_valid_after_ack", {31'd0, bus.out_valid}, 32'd0);
        chk("en_sent_count", {16'd0, bus.sent_count}, 32'd7);
        bus.out_ack = 1'b0;

        // enable low in IDLE: no grant, no pop
        enable       = 1'b0;
        bus.rd_ready = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("dis_rd_select", {28'd0, bus.rd_select}, 32'd0);
        end
        enable = 1'b1;

        // 6: reset during CAPTURE, then rr_ptr restarts at 0
        step();
        chk("t6_rd_select", {28'd0, bus.rd_select}, 32'h4);
        bus.rd_ready = 4'b0000;
        step();
        bus.rd_packet = 32'h7777_0000;
        reset         = 1'b0;
        step();
        chk("t6_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("t6_rst_out_packet", bus.out_packet, 32'd0);
        chk("t6_rst_out_pp", {30'd0, bus.out_pp}, 32'd0);
        chk("t6_rst_sent_count", {16'd0, bus.sent_count}, 32'd0);
        chk("t6_rst_rd_select", {28'd0, bus.rd_select}, 32'd0);
        reset         = 1'b1;
        bus.rd_packet = 32'hDEAD_0000;
        bus.rd_ready  = 4'b1001;
        step();
        chk("t6_rd_select_rr0", {28'd0, bus.rd_select}, 32'h1);
        bus.rd_ready = 4'b0000;
        step();
        bus.rd_packet = 32'h5555_AA11;
        step();
        chk("t6_out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("t6_out_packet", bus.out_packet, 32'h5555_AA11);
        chk("t6_out_pp", {30'd0, bus.out_pp}, 32'd0);
        bus.rd_packet = 32'hDEAD_0000;
        bus.out_ack   = 1'b1;
        step();
        chk("t6_sent_count", {16'd0, bus.sent_count}, 32'd1);
        bus.out_ack = 1'b0;

`ifdef TIMESTAMP_GATE_EN
        // 5: timestamp gate, simple and across wrap
        bus.rd_ready = 4'b0010;
        step();
        bus.rd_ready = 4'b0000;
        step();
        bus.rd_packet = 32'h0000_0005;
        sim_time      = 8'h02;
        step();
        bus.rd_packet = 32'hDEAD_0000;
        bus.out_ack   = 1'b1;
        for (int t = 2; t < 5; t++) begin
            sim_time = 8'(t);
            step();
            chk("t5_not_due", {31'd0, bus.out_valid}, 32'd0);
            chk("t5_sent_hold", {16'd0, bus.sent_count}, 32'd1);
        end
        sim_time = 8'h05;
        #1;
        chk("t5_due", {31'd0, bus.out_valid}, 32'd1);
        step();
        chk("t5_sent_count", {16'd0, bus.sent_count}, 32'd2);
        bus.out_ack  = 1'b0;
        sim_time     = 8'h7F;
        bus.rd_ready = 4'b0100;
        step();
        bus.rd_ready = 4'b0000;
        step();
        bus.rd_packet = 32'h0000_0002;
        sim_time      = 8'hFE;
        step();
        bus.rd_packet = 32'hDEAD_0000;
        bus.out_ack   = 1'b1;
        for (int t = 0; t < 4; t++) begin
            sim_time = 8'(8'hFE + t);
            step();
            chk("t5_wrap_not_due", {31'd0, bus.out_valid}, 32'd0);
        end
        sim_time = 8'h02;
        #1;
        chk("t5_wrap_due", {31'd0, bus.out_valid}, 32'd1);
        step();
        chk("t5_wrap_sent_count", {16'd0, bus.sent_count}, 32'd3);
        bus.out_ack = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
